// File: rtl/cache_arbiter_pkg.sv
// rtl/cache_arbiter_pkg.sv - shared encodings for the cache arbiter
package cache_arbiter_pkg;
  localparam int NCORE = 4;

  localparam logic [1:0] MODE_RD   = 2'b00;
  localparam logic [1:0] MODE_WR   = 2'b11;
  localparam logic [1:0] MODE_IDLE = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/cache_arbiter_rr.sv
// rtl/cache_arbiter_rr.sv - combinational 4-way round-robin pick starting at ptr
module rr_arbiter_4
  import cache_arbiter_pkg::*;
(
  input  logic [NCORE-1:0] req,
  input  logic [1:0]       ptr,
  output logic [NCORE-1:0] gnt,
  output logic [1:0]       idx
);
  logic       found;
  logic [1:0] k;

  always_comb begin
    gnt   = '0;
    idx   = ptr;
    found = 1'b0;
    k     = ptr;
    for (int i = 0; i < NCORE; i++) begin
      k = ptr + i[1:0];
      if (!found && req[k]) begin
        gnt[k] = 1'b1;
        idx    = k;
        found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - serialises four cores' word accesses onto the shared cache
// Optional CACHE_ARB_STATS_EN adds per-core saturating ack counters on stat_cnt.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int         DW        = 64,
  parameter int         AW        = 32,
  parameter logic [1:0] IDLE_MODE = MODE_IDLE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCORE-1:0]    req,
  input  logic [NCORE-1:0]    we,
  input  logic [NCORE*AW-1:0] addr,
  input  logic [NCORE*DW-1:0] wdata,
  output logic [NCORE-1:0]    ack,
  output logic [DW-1:0]       rdata,
  output logic [1:0]          c_mode,
  output logic [AW-1:0]       c_st,
  output logic [DW-1:0]       c_in,
  input  logic [DW-1:0]       c_out
`ifdef CACHE_ARB_STATS_EN
  ,
  output logic [NCORE*16-1:0] stat_cnt
`endif
);
  state_t           state;
  logic [1:0]       rr_ptr;
  logic [1:0]       g;
  logic [NCORE-1:0] g_oh;
  logic             we_g;
  logic [NCORE-1:0] gnt;
  logic [1:0]       idx;

  rr_arbiter_4 u_rr (
    .req (req),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (idx)
  );

  // Outputs are registered one state early so c_mode is live exactly while in ISSUE
  // and ack/rdata exactly while in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      rr_ptr <= 2'd0;
      g      <= 2'd0;
      g_oh   <= '0;
      we_g   <= 1'b0;
      ack    <= '0;
      rdata  <= '0;
      c_mode <= IDLE_MODE;
      c_st   <= '0;
      c_in   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ack <= '0;
          if (req != '0) begin
            g      <= idx;
            g_oh   <= gnt;
            we_g   <= we[idx];
            c_mode <= we[idx] ? MODE_WR : MODE_RD;
            c_st   <= addr[idx*AW +: AW];
            c_in   <= wdata[idx*DW +: DW];
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!we_g) rdata <= c_out;
          ack    <= g_oh;
          c_mode <= IDLE_MODE;
          rr_ptr <= g + 2'd1;
          state  <= ST_DONE;
        end
        default: begin
          ack   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cnt <= '0;
    end else begin
      for (int k = 0; k < NCORE; k++) begin
        if (ack[k] && stat_cnt[k*16 +: 16] != 16'hFFFF)
          stat_cnt[k*16 +: 16] <= stat_cnt[k*16 +: 16] + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - table and sequence checks of cache_arbiter against a cache model
module tb_cache_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = '0;
  logic [3:0]   we = '0;
  logic [127:0] addr = '0;
  logic [255:0] wdata = '0;
  logic [3:0]   ack;
  logic [63:0]  rdata;
  logic [1:0]   c_mode;
  logic [31:0]  c_st;
  logic [63:0]  c_in;
  logic [63:0]  c_out;
`ifdef CACHE_ARB_STATS_EN
  logic [63:0]  stat_cnt;
`endif

  cache_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .ack    (ack),
    .rdata  (rdata),
    .c_mode (c_mode),
    .c_st   (c_st),
    .c_in   (c_in),
    .c_out  (c_out)
`ifdef CACHE_ARB_STATS_EN
    , .stat_cnt (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input logic [10:0] a);
    return {16'hA5A5, 37'h0, a};
  endfunction

  logic [63:0] mem [2048];
  initial for (int i = 0; i < 2048; i++) mem[i] = pat(i[10:0]);
  always @(posedge clk) if (c_mode == 2'b11) mem[c_st[10:0]] <= c_in;
  assign c_out = mem[c_st[10:0]];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic [3:0] ack; logic [63:0] rdata; } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [63:0] last_rd = '0;
  logic prev_active = 1'b0;
  int gap_viol = 0;

  always @(negedge clk) begin
    if (ack != '0) begin
      if (sb.size() == 0) check("unexpected_ack", {60'h0, ack}, 64'h0);
      else begin
        e = sb.pop_front();
        check("ack", {60'h0, ack}, {60'h0, e.ack});
        check("rdata", rdata, e.rdata);
      end
    end
    if (!rst && prev_active && c_mode != 2'b01) gap_viol++;
    prev_active = !rst && (c_mode == 2'b11 || c_mode == 2'b00);
  end

  task automatic wait_ack(input int core, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack[core] && n < 10);
    if (!ack[core]) check("ack_timeout", 64'(n), 64'd0);
  endtask

  task automatic push_exp(input int core, input logic wr, input logic [63:0] ex);
    exp_t x;
    x.ack = 4'b0001 << core;
    if (!wr) last_rd = ex;
    x.rdata = last_rd;
    sb.push_back(x);
  endtask

  task automatic single(input int core, input logic wr, input logic [31:0] a,
                        input logic [63:0] d, input logic [63:0] ex);
    int n;
    @(negedge clk);
    req[core] = 1'b1;
    we[core] = wr;
    addr[core*32 +: 32] = a;
    wdata[core*64 +: 64] = d;
    push_exp(core, wr, ex);
    wait_ack(core, n);
    check("latency", 64'(n), 64'd2);
    check("mode_idle_at_ack", {62'h0, c_mode}, 64'h1);
    req[core] = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd = '0;
  endtask

  typedef struct { int core; logic wr; logic [31:0] a; logic [63:0] d; logic [63:0] ex; } vec_t;
  vec_t tbl[8];

  initial begin
    int t[4];
    int n;
    tbl[0] = '{0, 1'b1, 32'h0000_0011, 64'h1111_0000_1111_1111, 64'h0};
    tbl[1] = '{0, 1'b0, 32'h0000_0011, 64'h0, 64'h1111_0000_1111_1111};
    tbl[2] = '{2, 1'b1, 32'h0000_0005, 64'hAAAA_AAAA_0000_0001, 64'h0};
    tbl[3] = '{2, 1'b1, 32'h0000_0005, 64'hBBBB_BBBB_0000_0002, 64'h0};
    tbl[4] = '{1, 1'b0, 32'h0000_0005, 64'h0, 64'hBBBB_BBBB_0000_0002};
    tbl[5] = '{3, 1'b0, 32'h0000_07FF, 64'h0, pat(11'h7FF)};
    tbl[6] = '{1, 1'b1, 32'hFFFF_F801, 64'hCCCC_1234_5678_9ABC, 64'h0};
    tbl[7] = '{0, 1'b0, 32'h0000_0001, 64'h0, 64'hCCCC_1234_5678_9ABC};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {60'h0, ack}, 64'h0);
    check("rst_rdata", rdata, 64'h0);
    check("rst_mode", {62'h0, c_mode}, 64'h1);
    check("rst_st", {32'h0, c_st}, 64'h0);
    check("rst_in", c_in, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      single(tbl[i].core, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].ex);

    // All four request at once right after reset: expect 0,1,2,3 three cycles apart.
    reset_pulse();
    @(negedge clk);
    we = '0;
    for (int k = 0; k < 4; k++) begin
      addr[k*32 +: 32] = 32'h100 + k;
      push_exp(k, 1'b0, pat(11'h100 + 11'(k)));
      t[k] = 0;
    end
    req = 4'hF;
    n = 0;
    while (req != '0 && n < 30) begin
      @(negedge clk);
      n++;
      for (int k = 0; k < 4; k++) if (ack[k]) begin t[k] = cyc; req[k] = 1'b0; end
    end
    check("all4_done", {60'h0, req}, 64'h0);
    for (int k = 1; k < 4; k++) check("all4_spacing", 64'(t[k] - t[k-1]), 64'd3);
    single(2, 1'b0, 32'h0000_0005, 64'h0, 64'hBBBB_BBBB_0000_0002);

    // Reset lands while a core 1 read is in ISSUE.
    @(negedge clk);
    req[1] = 1'b1;
    we[1] = 1'b0;
    addr[32 +: 32] = 32'h0000_0011;
    @(negedge clk);
    check("abort_issue_mode", {62'h0, c_mode}, 64'h0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ack", {60'h0, ack}, 64'h0);
    check("abort_mode", {62'h0, c_mode}, 64'h1);
    check("abort_rdata", rdata, 64'h0);
    check("abort_rr_ptr", {62'h0, dut.rr_ptr}, 64'h0);
    rst = 1'b0;
    req = '0;
    last_rd = '0;
    repeat (3) @(negedge clk);

    // Core 3 keeps req high past its ack and must be served again.
    @(negedge clk);
    req[3] = 1'b1;
    we[3] = 1'b0;
    addr[96 +: 32] = 32'h0000_0022;
    push_exp(3, 1'b0, pat(11'h022));
    push_exp(3, 1'b0, pat(11'h022));
    wait_ack(3, n);
    check("hold_first_latency", 64'(n), 64'd2);
    wait_ack(3, n);
    check("hold_second_spacing", 64'(n), 64'd3);
    check("hold_rr_ptr", {62'h0, dut.rr_ptr}, 64'h0);
    req[3] = 1'b0;
    repeat (3) @(negedge clk);

`ifdef CACHE_ARB_STATS_EN
    reset_pulse();
    for (int i = 0; i < 5; i++) single(1, 1'b0, 32'h30 + i, 64'h0, pat(11'h030 + 11'(i)));
    @(negedge clk);
    check("stat_core1", {48'h0, stat_cnt[31:16]}, 64'd5);
    check("stat_core0", {48'h0, stat_cnt[15:0]}, 64'd0);
    reset_pulse();
    check("stat_clear", stat_cnt, 64'h0);
`endif

    repeat (4) @(negedge clk);
    check("mode_gap_violations", 64'(gap_viol), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
